mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares one SRAM-like memory port between the instruction-fetch requester and the data-access requester. Sits between the fetch/memory pipeline stages and the single external memory interface (later the AXI bridge). Grants one transaction at a time, latches its request fields, drives the shared port through address and data phases, and routes the response back to the owner. Ties are broken round-robin.

## Interface
- ADDR_W, 32, address width for all three sides
- DATA_W, 32, data width for all three sides
- clk  in  1  system clock, rising edge
- resetn  in  1  asynchronous active-low reset
- inst_req  in  1  fetch request; held until inst_addr_ok
- inst_addr  in  ADDR_W  fetch address
- inst_addr_ok  out  1  fetch request accepted (grant)
- inst_data_ok  out  1  fetch read data valid
- inst_rdata  out  DATA_W  fetch read data
- data_req  in  1  data request; held until data_addr_ok
- data_wr  in  1  1 = write, 0 = read
- data_wstrb  in  DATA_W/8  byte write strobes
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  write data
- data_addr_ok  out  1  data request accepted (grant)
- data_data_ok  out  1  read data valid / write done
- data_rdata  out  DATA_W  data read data
- mem_req  out  1  shared-port request
- mem_wr  out  1  shared-port write enable
- mem_wstrb  out  DATA_W/8  shared-port strobes
- mem_addr  out  ADDR_W  shared-port address
- mem_wdata  out  DATA_W  shared-port write data
- mem_addr_ok  in  1  slave accepted address phase
- mem_data_ok  in  1  slave response valid
- mem_rdata  in  DATA_W  slave read data
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ADDR, DATA. One outstanding transaction maximum.
- IDLE: if exactly one req is high, grant it. If both are high, grant the requester not in `last_owner`. Grant means:
  - assert that side's addr_ok combinationally in the same cycle;
  - latch owner, addr, wr, wstrb, and wdata into mem_* registers;
  - set `last_owner`;
  - go to ADDR.
- Inst grants always latch wr=0 and wstrb=0.
- ADDR: mem_req=1, mem_* fields stable. On mem_addr_ok, go to DATA and drop mem_req next cycle. New requests are not granted; both addr_ok outputs stay 0.
- DATA: mem_req=0. On mem_data_ok, pulse the owner's data_ok in the same cycle (combinational from mem_data_ok & state==DATA & owner), then go to IDLE.
- inst_rdata = data_rdata = mem_rdata (wires). Content is meaningful only while the corresponding data_ok is high.
- mem_data_ok outside DATA and mem_addr_ok outside ADDR are ignored.
- Requester deasserting req without addr_ok is a protocol violation; the arbiter need not handle it.

## Timing
- Reset (async, immediate):
  - state=IDLE, last_owner=INST;
  - mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata = 0;
  - all addr_ok/data_ok = 0, busy=0.
  - A transaction in flight is abandoned; any late slave response after reset release is ignored.
- Grant latency: req high in IDLE → addr_ok same cycle (T0), mem_req high from T1.
- Minimum round trip: mem_addr_ok at T1, mem_data_ok at T2 → owner data_ok at T2, IDLE at T3. Next grant is possible at T3.
- Back-to-back with both requesting and last_owner=INST: data granted T0, inst granted at T3 (earliest). Strict alternation follows while both stay high.
- Slave stalls: mem_req and fields hold indefinitely in ADDR. DATA waits indefinitely.
- Never more than one addr_ok or data_ok high in any cycle.

## Test plan
- Reset release with no requests → all outputs 0, busy=0 for 10 cycles. Assert resetn low in ADDR → mem_req drops immediately, state IDLE.
- Single inst read: inst_req at T0, addr 0x1c000000 → inst_addr_ok T0, mem_req=1/mem_addr=0x1c000000/mem_wr=0 T1. Slave addr_ok T1, data_ok T2 with 0x02800000 → inst_data_ok=1 and inst_rdata=0x02800000 at T2, busy=0 at T3.
- Data write: data_req with wr=1, wstrb=4'b0011, addr 0x1c001004, wdata 0xdeadbeef → mem_* carry exactly those values during ADDR. Slave delays addr_ok 3 cycles → fields stable throughout; data_data_ok on response.
- Simultaneous requests from reset: both req high continuously, zero-wait slave → grants alternate data, inst, data, inst. Each requester receives data_ok only for its own transaction.
- Stray responses: mem_data_ok pulsed in IDLE and in ADDR → no data_ok output, state unchanged.
- Request arriving in DATA: data_req rises while an inst transaction waits 5 cycles for data_ok → data_addr_ok stays 0 until the cycle after inst_data_ok, then is granted.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one SRAM-like memory port between the fetch and data requesters.
// One transaction in flight at a time: grant in IDLE, address phase in ADDR, response in DATA.
module mem_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  inst_req,
    input  logic [ADDR_W-1:0]     inst_addr,
    output logic                  inst_addr_ok,
    output logic                  inst_data_ok,
    output logic [DATA_W-1:0]     inst_rdata,
    input  logic                  data_req,
    input  logic                  data_wr,
    input  logic [DATA_W/8-1:0]   data_wstrb,
    input  logic [ADDR_W-1:0]     data_addr,
    input  logic [DATA_W-1:0]     data_wdata,
    output logic                  data_addr_ok,
    output logic                  data_data_ok,
    output logic [DATA_W-1:0]     data_rdata,
    output logic                  mem_req,
    output logic                  mem_wr,
    output logic [DATA_W/8-1:0]   mem_wstrb,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_addr_ok,
    input  logic                  mem_data_ok,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

    state_t                state_q, state_d;
    logic                  owner_q, owner_d;
    logic                  last_owner_q, last_owner_d;
    logic                  mem_wr_q, mem_wr_d;
    logic [DATA_W/8-1:0]   mem_wstrb_q, mem_wstrb_d;
    logic [ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]     mem_wdata_q, mem_wdata_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            owner_q      <= OWN_INST;
            last_owner_q <= OWN_INST;
            mem_wr_q     <= 1'b0;
            mem_wstrb_q  <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_wr_q     <= mem_wr_d;
            mem_wstrb_q  <= mem_wstrb_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_wr_d     = mem_wr_q;
        mem_wstrb_d  = mem_wstrb_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        inst_addr_ok = 1'b0;
        data_addr_ok = 1'b0;
        inst_data_ok = 1'b0;
        data_data_ok = 1'b0;

        case (state_q)
            IDLE: begin
                // On a tie the side that did not win last time goes first.
                if (inst_req && (!data_req || last_owner_q == OWN_DATA)) begin
                    inst_addr_ok = 1'b1;
                    owner_d      = OWN_INST;
                    last_owner_d = OWN_INST;
                    mem_wr_d     = 1'b0;
                    mem_wstrb_d  = '0;
                    mem_addr_d   = inst_addr;
                    mem_wdata_d  = '0;
                    state_d      = ADDR;
                end else if (data_req) begin
                    data_addr_ok = 1'b1;
                    owner_d      = OWN_DATA;
                    last_owner_d = OWN_DATA;
                    mem_wr_d     = data_wr;
                    mem_wstrb_d  = data_wstrb;
                    mem_addr_d   = data_addr;
                    mem_wdata_d  = data_wdata;
                    state_d      = ADDR;
                end
            end
            ADDR: begin
                if (mem_addr_ok) begin
                    state_d = DATA;
                end
            end
            DATA: begin
                if (mem_data_ok) begin
                    inst_data_ok = (owner_q == OWN_INST);
                    data_data_ok = (owner_q == OWN_DATA);
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mem_req    = (state_q == ADDR);
    assign mem_wr     = mem_wr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;
    assign busy       = (state_q != IDLE);
    assign inst_rdata = mem_rdata;
    assign data_rdata = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed requester stimulus, a scripted slave,
// and a negedge monitor that pops expected grants/responses as the DUT presents them.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int SW = DW / 8;

    logic          clk = 1'b0;
    logic          resetn;
    logic          inst_req;
    logic [AW-1:0] inst_addr;
    logic          inst_addr_ok, inst_data_ok;
    logic [DW-1:0] inst_rdata;
    logic          data_req, data_wr;
    logic [SW-1:0] data_wstrb;
    logic [AW-1:0] data_addr;
    logic [DW-1:0] data_wdata;
    logic          data_addr_ok, data_data_ok;
    logic [DW-1:0] data_rdata;
    logic          mem_req, mem_wr;
    logic [SW-1:0] mem_wstrb;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_addr_ok, mem_data_ok;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_wstrb(mem_wstrb), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    typedef struct {
        bit            who;
        logic [AW-1:0] addr;
        logic          wr;
        logic [SW-1:0] wstrb;
        logic [DW-1:0] wdata;
    } grant_t;

    typedef struct {
        bit            who;
        bit            chk_data;
        logic [DW-1:0] rdata;
    } resp_t;

    grant_t        exp_g_q[$];
    resp_t         exp_r_q[$];
    logic [DW-1:0] slv_rdata_q[$];
    int            grant_cyc[$];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_grants = 0;

    bit slave_en = 1'b0;
    int sl_phase = 0;
    int sl_cnt = 0;
    int addr_delay = 0;
    int data_delay = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_timeout(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    function automatic grant_t mk_grant(input bit who, input logic [AW-1:0] a, input logic w,
                                        input logic [SW-1:0] s, input logic [DW-1:0] d);
        grant_t g;
        g.who = who; g.addr = a; g.wr = w; g.wstrb = s; g.wdata = d;
        return g;
    endfunction

    function automatic resp_t mk_resp(input bit who, input bit c, input logic [DW-1:0] d);
        resp_t r;
        r.who = who; r.chk_data = c; r.rdata = d;
        return r;
    endfunction

    // Monitor: grants are checked on the addr_ok cycle, latched fields one cycle later.
    initial begin
        grant_t pend;
        grant_t g;
        resp_t  r;
        bit     pend_v = 1'b0;
        forever begin
            @(negedge clk);
            if (pend_v) begin
                chk("grant_mem_req", mem_req, 1'b1);
                chk("grant_fields", {mem_wr, mem_wstrb, mem_addr, mem_wdata},
                    {pend.wr, pend.wstrb, pend.addr, pend.wdata});
                pend_v = 1'b0;
            end
            if (inst_addr_ok || data_addr_ok) begin
                chk("addr_ok_onehot", inst_addr_ok & data_addr_ok, 1'b0);
                if (exp_g_q.size() == 0) begin
                    chk("grant_unexpected", exp_g_q.size(), 1);
                end else begin
                    g = exp_g_q.pop_front();
                    chk("grant_who", data_addr_ok, g.who);
                    pend = g;
                    pend_v = 1'b1;
                end
                n_grants++;
                grant_cyc.push_back(cyc);
            end
            if (inst_data_ok || data_data_ok) begin
                chk("data_ok_onehot", inst_data_ok & data_data_ok, 1'b0);
                if (exp_r_q.size() == 0) begin
                    chk("resp_unexpected", exp_r_q.size(), 1);
                end else begin
                    r = exp_r_q.pop_front();
                    chk("resp_who", data_data_ok, r.who);
                    if (r.chk_data)
                        chk("resp_rdata", r.who ? data_rdata : inst_rdata, r.rdata);
                end
            end
        end
    end

    // Scripted slave: addr_ok addr_delay cycles after mem_req, data_ok data_delay cycles later.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (slave_en) begin
                mem_addr_ok = 1'b0;
                mem_data_ok = 1'b0;
                case (sl_phase)
                    0: if (mem_req) begin
                        if (addr_delay == 0) begin
                            mem_addr_ok = 1'b1; sl_phase = 2; sl_cnt = 0;
                        end else begin
                            sl_phase = 1; sl_cnt = 1;
                        end
                    end
                    1: if (sl_cnt == addr_delay) begin
                        mem_addr_ok = 1'b1; sl_phase = 2; sl_cnt = 0;
                    end else begin
                        sl_cnt++;
                    end
                    default: if (sl_cnt == data_delay) begin
                        mem_data_ok = 1'b1;
                        mem_rdata = (slv_rdata_q.size() != 0) ? slv_rdata_q.pop_front() : '0;
                        sl_phase = 0;
                    end else begin
                        sl_cnt++;
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_addr_ok(input bit who, input string name);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (who ? data_addr_ok : inst_addr_ok) return;
        end
        fail_timeout(name);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        fail_timeout(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit seen;
        resetn = 1'b0;
        inst_req = 0; inst_addr = '0;
        data_req = 0; data_wr = 0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
        repeat (3) tick();
        resetn = 1'b1;

        // Idle after reset.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_idle_outputs",
                {mem_req, mem_wr, mem_wstrb, mem_addr, mem_wdata,
                 inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, busy}, '0);
        end

        // Single inst read, zero-wait slave.
        slave_en = 1'b1; addr_delay = 0; data_delay = 0;
        tick();
        inst_req = 1'b1; inst_addr = 32'h1c000000;
        exp_g_q.push_back(mk_grant(0, 32'h1c000000, 0, '0, '0));
        exp_r_q.push_back(mk_resp(0, 1, 32'h02800000));
        slv_rdata_q.push_back(32'h02800000);
        @(negedge clk);
        chk("inst_addr_ok_t0", inst_addr_ok, 1'b1);
        tick();
        inst_req = 1'b0;
        @(negedge clk);
        chk("inst_mem_t1", {mem_req, mem_wr, mem_addr}, {1'b1, 1'b0, 32'h1c000000});
        tick();
        @(negedge clk);
        chk("inst_data_ok_t2", {inst_data_ok, inst_rdata}, {1'b1, 32'h02800000});
        tick();
        @(negedge clk);
        chk("inst_busy_t3", busy, 1'b0);

        // Data write with a 3-cycle address stall.
        addr_delay = 3;
        tick();
        data_req = 1; data_wr = 1; data_wstrb = 4'b0011;
        data_addr = 32'h1c001004; data_wdata = 32'hdeadbeef;
        exp_g_q.push_back(mk_grant(1, 32'h1c001004, 1, 4'b0011, 32'hdeadbeef));
        exp_r_q.push_back(mk_resp(1, 0, '0));
        wait_addr_ok(1, "wr_grant");
        tick();
        data_req = 0; data_wr = 0; data_wstrb = '0;
        n = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!busy) break;
            if (mem_req) begin
                chk("wr_fields_stable", {mem_wr, mem_wstrb, mem_addr, mem_wdata},
                    {1'b1, 4'b0011, 32'h1c001004, 32'hdeadbeef});
                n++;
            end
        end
        chk("wr_addr_phase_len", n, 4);
        addr_delay = 0;

        // Reset asserted in ADDR with a stalled slave, then a late response.
        tick();
        slave_en = 1'b0;
        inst_req = 1'b1; inst_addr = 32'h1c000100;
        exp_g_q.push_back(mk_grant(0, 32'h1c000100, 0, '0, '0));
        wait_addr_ok(0, "rst_grant");
        tick();
        inst_req = 1'b0;
        @(negedge clk);
        chk("rst_pre_mem_req", mem_req, 1'b1);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        chk("rst_async_clear", {mem_req, busy, mem_addr}, '0);
        tick();
        resetn = 1'b1;
        sl_phase = 0;
        mem_data_ok = 1'b1;
        @(negedge clk);
        chk("late_resp_ignored", busy, 1'b0);
        tick();
        mem_data_ok = 1'b0;

        // Both requesting from reset: data, inst, data, inst.
        slave_en = 1'b1;
        inst_req = 1; inst_addr = 32'h1c000200;
        data_req = 1; data_wr = 0; data_wstrb = '0;
        data_addr = 32'h1c002000; data_wdata = 32'h12345678;
        for (int i = 0; i < 2; i++) begin
            exp_g_q.push_back(mk_grant(1, 32'h1c002000, 0, '0, 32'h12345678));
            exp_r_q.push_back(mk_resp(1, 1, 32'hd0000000 + i));
            slv_rdata_q.push_back(32'hd0000000 + i);
            exp_g_q.push_back(mk_grant(0, 32'h1c000200, 0, '0, '0));
            exp_r_q.push_back(mk_resp(0, 1, 32'h10000000 + i));
            slv_rdata_q.push_back(32'h10000000 + i);
        end
        n = n_grants + 4;
        seen = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (n_grants >= n) begin seen = 1'b1; break; end
        end
        if (!seen) fail_timeout("alt_grants");
        tick();
        inst_req = 0; data_req = 0;
        wait_idle("alt_idle");
        for (int i = grant_cyc.size() - 3; i < grant_cyc.size(); i++)
            chk("alt_spacing", grant_cyc[i] - grant_cyc[i-1], 3);

        // Stray responses in IDLE and ADDR.
        tick();
        slave_en = 1'b0;
        sl_phase = 0;
        mem_data_ok = 1; mem_addr_ok = 1;
        @(negedge clk);
        chk("stray_idle_busy", busy, 1'b0);
        tick();
        mem_data_ok = 0; mem_addr_ok = 0;
        inst_req = 1; inst_addr = 32'h1c000300;
        exp_g_q.push_back(mk_grant(0, 32'h1c000300, 0, '0, '0));
        exp_r_q.push_back(mk_resp(0, 1, 32'h55aa55aa));
        wait_addr_ok(0, "stray_grant");
        tick();
        inst_req = 0;
        mem_data_ok = 1;
        @(negedge clk);
        chk("stray_addr_state", {busy, mem_req}, 2'b11);
        tick();
        mem_data_ok = 0;
        @(negedge clk);
        chk("stray_addr_hold", mem_req, 1'b1);
        tick();
        slv_rdata_q.push_back(32'h55aa55aa);
        slave_en = 1'b1;
        wait_idle("stray_idle");

        // Data request arriving while an inst transaction waits in DATA.
        data_delay = 5;
        tick();
        inst_req = 1; inst_addr = 32'h1c000400;
        exp_g_q.push_back(mk_grant(0, 32'h1c000400, 0, '0, '0));
        exp_r_q.push_back(mk_resp(0, 1, 32'h0badf00d));
        slv_rdata_q.push_back(32'h0badf00d);
        wait_addr_ok(0, "late_inst_grant");
        tick();
        inst_req = 0;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy && !mem_req) begin seen = 1'b1; break; end
        end
        if (!seen) fail_timeout("late_reach_data");
        tick();
        data_req = 1; data_wr = 1; data_wstrb = 4'hf;
        data_addr = 32'h1c003000; data_wdata = 32'hcafef00d;
        exp_g_q.push_back(mk_grant(1, 32'h1c003000, 1, 4'hf, 32'hcafef00d));
        exp_r_q.push_back(mk_resp(1, 0, '0));
        slv_rdata_q.push_back('0);
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (inst_data_ok) begin seen = 1'b1; break; end
            chk("no_grant_in_data", data_addr_ok, 1'b0);
        end
        if (!seen) fail_timeout("late_inst_data_ok");
        @(negedge clk);
        chk("grant_after_data_ok", data_addr_ok, 1'b1);
        tick();
        data_req = 0; data_wr = 0; data_wstrb = '0;
        data_delay = 0;
        wait_idle("late_final_idle");

        repeat (3) tick();
        chk("grant_queue_drained", exp_g_q.size(), 0);
        chk("resp_queue_drained", exp_r_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
